// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types and bar colour table for the video timing generator
package video_pkg;

  typedef enum logic [1:0] {
    MODE_STREAM   = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_GRID     = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_t;

  // Per-channel on/off flags; a set flag means full-scale on that channel.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam int NUM_BARS = 8;

  function automatic rgb_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return rgb_t'(3'b111);
      3'd1:    return rgb_t'(3'b110);
      3'd2:    return rgb_t'(3'b011);
      3'd3:    return rgb_t'(3'b010);
      3'd4:    return rgb_t'(3'b101);
      3'd5:    return rgb_t'(3'b100);
      3'd6:    return rgb_t'(3'b001);
      default: return rgb_t'(3'b000);
    endcase
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - pixel stream input and video pin output bundle
interface video_timing_gen_if
  import video_pkg::*;
#(
  parameter int COLOR_W = 8
);
  logic [3*COLOR_W-1:0] pix_data;
  logic                 pix_valid;
  logic                 pix_req;
  logic                 vga_hs;
  logic                 vga_vs;
  logic                 vga_blank;
  logic [3*COLOR_W-1:0] vga_rgb;

  modport master (
    input  pix_data, pix_valid,
    output pix_req, vga_hs, vga_vs, vga_blank, vga_rgb
  );

  modport slave (
    output pix_data, pix_valid,
    input  pix_req, vga_hs, vga_vs, vga_blank, vga_rgb
  );
endinterface

// File: rtl/video_sync_counter.sv
// rtl/video_sync_counter.sv - h/v raster counters with active, sync and frame-start decode
module video_sync_counter
  import video_pkg::*;
#(
  parameter int HDISP  = 800,
  parameter int HFP    = 40,
  parameter int HPULSE = 128,
  parameter int HBP    = 88,
  parameter int VDISP  = 480,
  parameter int VFP    = 1,
  parameter int VPULSE = 3,
  parameter int VBP    = 21,
  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP,
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP,
  localparam int XW     = $clog2(HTOTAL),
  localparam int YW     = $clog2(VTOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  output logic [XW-1:0] hcnt,
  output logic [YW-1:0] vcnt,
  output logic          active,
  output logic          hs_act,
  output logic          vs_act,
  output logic          frame_start
);

  localparam int HS_START = HDISP + HFP;
  localparam int VS_START = VDISP + VFP;

  if (HDISP < 8 || HFP < 1 || HPULSE < 1 || HBP < 1 ||
      VDISP < 1 || VFP < 1 || VPULSE < 1 || VBP < 1) begin : g_bad_timing
    $error("video_sync_counter: illegal timing parameters");
  end

  logic [XW-1:0] hcnt_q, hcnt_d;
  logic [YW-1:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (!enable) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (hcnt_q == XW'(HTOTAL - 1)) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == YW'(VTOTAL - 1)) ? '0 : vcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign active      = (int'(hcnt_q) < HDISP) && (int'(vcnt_q) < VDISP);
  assign hs_act      = (int'(hcnt_q) >= HS_START) && (int'(hcnt_q) < HS_START + HPULSE);
  assign vs_act      = (int'(vcnt_q) >= VS_START) && (int'(vcnt_q) < VS_START + VPULSE);
  // Gated so a disabled generator parked at (0,0) does not pulse every cycle.
  assign frame_start = enable && (hcnt_q == '0) && (vcnt_q == '0);

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - video timing generator with stream/bars/grid/gradient pixel source
module video_timing_gen
  import video_pkg::*;
#(
  parameter int HDISP  = 800,
  parameter int HFP    = 40,
  parameter int HPULSE = 128,
  parameter int HBP    = 88,
  parameter int VDISP  = 480,
  parameter int VFP    = 1,
  parameter int VPULSE = 3,
  parameter int VBP    = 21,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int COLOR_W = 8,
  parameter logic [3*COLOR_W-1:0] UNDERFLOW_RGB = 24'hFF0000,
  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP,
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP,
  localparam int XW     = $clog2(HTOTAL),
  localparam int YW     = $clog2(VTOTAL),
  localparam int PIX_W  = 3 * COLOR_W
) (
  input  logic               pixel_clk,
  input  logic               pixel_rst_n,
  input  logic               enable,
  input  mode_t              mode,
  video_timing_gen_if.master vif,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic               frame_start,
  output logic               underflow,
  output logic [15:0]        underflow_cnt
);

  localparam int BAR_W = HDISP / NUM_BARS;

  if (COLOR_W > 16 || COLOR_W < 1) begin : g_bad_color_w
    $error("video_timing_gen: COLOR_W must be 1..16");
  end

  logic [XW-1:0] hcnt;
  logic [YW-1:0] vcnt;
  logic          active, hs_act, vs_act, fs;

  video_sync_counter #(
    .HDISP (HDISP), .HFP (HFP), .HPULSE (HPULSE), .HBP (HBP),
    .VDISP (VDISP), .VFP (VFP), .VPULSE (VPULSE), .VBP (VBP)
  ) u_sync (
    .clk         (pixel_clk),
    .rst_n       (pixel_rst_n),
    .enable      (enable),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .active      (active),
    .hs_act      (hs_act),
    .vs_act      (vs_act),
    .frame_start (fs)
  );

  mode_t            frame_mode_q, frame_mode_d, cur_mode;
  logic [2:0]       bar_idx_q, bar_idx_d, cur_bar_idx;
  logic [XW-1:0]    bar_px_q, bar_px_d, cur_bar_px;
  rgb_t             bar_flags;
  logic [PIX_W-1:0] pattern;
  logic             pix_req_c, under_ev;
  logic             hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic [PIX_W-1:0] rgb_q, rgb_d;
  logic             underflow_q, underflow_d;
  logic [15:0]      ucnt_q, ucnt_d;

  always_comb begin
    // The new mode already governs pixel (0,0) of the frame it is sampled for.
    cur_mode     = fs ? mode : frame_mode_q;
    frame_mode_d = cur_mode;
    pix_req_c    = active && enable && (cur_mode == MODE_STREAM);
    under_ev     = pix_req_c && !vif.pix_valid;

    // Bar position restarts at the line start; the last bar soaks up HDISP % 8.
    cur_bar_idx = (hcnt == '0) ? 3'd0 : bar_idx_q;
    cur_bar_px  = (hcnt == '0) ? '0 : bar_px_q;
    bar_idx_d   = cur_bar_idx;
    bar_px_d    = cur_bar_px + 1'b1;
    if ((int'(cur_bar_px) == BAR_W - 1) && (cur_bar_idx != 3'd7)) begin
      bar_idx_d = cur_bar_idx + 3'd1;
      bar_px_d  = '0;
    end
    bar_flags = bar_color(cur_bar_idx);

    case (cur_mode)
      MODE_STREAM: pattern = vif.pix_valid ? vif.pix_data : UNDERFLOW_RGB;
      MODE_BARS:   pattern = {{COLOR_W{bar_flags.r}}, {COLOR_W{bar_flags.g}}, {COLOR_W{bar_flags.b}}};
      MODE_GRID:   pattern = ((32'(hcnt) % 32'd16 == 32'd0) || (32'(vcnt) % 32'd16 == 32'd0)) ? '1 : '0;
      default:     pattern = {COLOR_W'(hcnt), COLOR_W'(vcnt), COLOR_W'(32'(hcnt) + 32'(vcnt))};
    endcase

    underflow_d = underflow_q | under_ev;
    ucnt_d      = (under_ev && (ucnt_q != 16'hFFFF)) ? ucnt_q + 16'd1 : ucnt_q;

    hs_d    = ~HSYNC_POL;
    vs_d    = ~VSYNC_POL;
    blank_d = 1'b1;
    rgb_d   = '0;
    if (enable) begin
      hs_d    = hs_act ? HSYNC_POL : ~HSYNC_POL;
      vs_d    = vs_act ? VSYNC_POL : ~VSYNC_POL;
      blank_d = ~active;
      rgb_d   = active ? pattern : '0;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      frame_mode_q <= MODE_STREAM;
      bar_idx_q    <= '0;
      bar_px_q     <= '0;
      hs_q         <= ~HSYNC_POL;
      vs_q         <= ~VSYNC_POL;
      blank_q      <= 1'b1;
      rgb_q        <= '0;
      underflow_q  <= 1'b0;
      ucnt_q       <= '0;
    end else begin
      frame_mode_q <= frame_mode_d;
      bar_idx_q    <= bar_idx_d;
      bar_px_q     <= bar_px_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      blank_q      <= blank_d;
      rgb_q        <= rgb_d;
      underflow_q  <= underflow_d;
      ucnt_q       <= ucnt_d;
    end
  end

  assign vif.pix_req   = pix_req_c;
  assign vif.vga_hs    = hs_q;
  assign vif.vga_vs    = vs_q;
  assign vif.vga_blank = blank_q;
  assign vif.vga_rgb   = rgb_q;
  assign x             = hcnt;
  assign y             = vcnt;
  assign frame_start   = fs;
  assign underflow     = underflow_q;
  assign underflow_cnt = ucnt_q;

endmodule
